// File: rtl/unidade_controle_rodadas.sv
// ============================================================================
// Module  : unidade_controle_rodadas
// Purpose : Moore control unit sequencing the round-based memory game
//           datapath, with per-play timeout and win/loss reporting.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module unidade_controle_rodadas #(
    parameter int N_RODADAS = 16,
    parameter int TIMEOUT   = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       jogada_feita,
    input  logic       jogada_correta,
    input  logic       endereco_igual_rodada,
    input  logic       fim_rodadas,
    output logic       zera_e,
    output logic       conta_e,
    output logic       zera_r,
    output logic       conta_r,
    output logic       registra_r,
    output logic       limpa_r,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] C_CNT_LIM = CW'(TIMEOUT - 1);

    if ((N_RODADAS < 1) || (TIMEOUT < 1)) begin : g_param_check
        $error("unidade_controle_rodadas: N_RODADAS and TIMEOUT must be >= 1");
    end

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } estado_t;

    // Output vector order:
    // {zera_e, conta_e, zera_r, conta_r, registra_r, limpa_r, ganhou, perdeu, pronto, db_timeout}
    function automatic logic [9:0] decodifica(input estado_t e);
        logic [9:0] s;
        s = '0;
        case (e)
            INICIAL:        s = 10'b1010000000;
            PREPARACAO:     s = 10'b1010010000;
            INICIA_RODADA:  s = 10'b1000000000;
            REGISTRA:       s = 10'b0000100000;
            PROXIMA_JOGADA: s = 10'b0100000000;
            PROXIMA_RODADA: s = 10'b0001000000;
            FIM_ACERTOU:    s = 10'b0000001010;
            FIM_ERROU:      s = 10'b0000000110;
            FIM_TIMEOUT:    s = 10'b0000000111;
            default:        s = '0;
        endcase
        return s;
    endfunction

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    saidas_q, saidas_d;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        case (estado_q)
            INICIAL:       if (jogar) estado_d = PREPARACAO;
            PREPARACAO:    estado_d = INICIA_RODADA;
            INICIA_RODADA: begin
                estado_d = ESPERA_JOGADA;
                cnt_d    = '0;
            end
            ESPERA_JOGADA: begin
                // A play arriving on the last allowed cycle still counts.
                if (jogada_feita) begin
                    estado_d = REGISTRA;
                end else if (cnt_q == C_CNT_LIM) begin
                    estado_d = FIM_TIMEOUT;
                end
                if (cnt_q != C_CNT_LIM) cnt_d = cnt_q + 1'b1;
            end
            REGISTRA:      estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!jogada_correta)                           estado_d = FIM_ERROU;
                else if (endereco_igual_rodada && fim_rodadas) estado_d = FIM_ACERTOU;
                else if (endereco_igual_rodada)                estado_d = PROXIMA_RODADA;
                else                                           estado_d = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: begin
                estado_d = ESPERA_JOGADA;
                cnt_d    = '0;
            end
            PROXIMA_RODADA: estado_d = INICIA_RODADA;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: if (jogar) estado_d = PREPARACAO;
            default:        estado_d = INICIAL;
        endcase
        // Outputs are registered from the next state so they line up with it.
        saidas_d = decodifica(estado_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
            cnt_q    <= '0;
            saidas_q <= decodifica(INICIAL);
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            saidas_q <= saidas_d;
        end
    end

    assign {zera_e, conta_e, zera_r, conta_r, registra_r,
            limpa_r, ganhou, perdeu, pronto, db_timeout} = saidas_q;
    assign db_estado = estado_q;

endmodule

`default_nettype wire

// File: tb/tb_unidade_controle_rodadas.sv
// Scoreboard bench: stimulus queues expected state/output vectors, a monitor
// compares them on every state change of the control unit.
`default_nettype none

module tb_unidade_controle_rodadas;

    localparam int N  = 16;
    localparam int TO = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic jogar = 1'b0;
    logic jogada_feita = 1'b0;
    logic jogada_correta = 1'b1;
    logic endereco_igual_rodada, fim_rodadas;
    logic zera_e, conta_e, zera_r, conta_r, registra_r, limpa_r;
    logic ganhou, perdeu, pronto, db_timeout;
    logic [3:0] db_estado;

    int n_tests = 0;
    int n_fail  = 0;
    int n_conta_e = 0;
    int n_conta_r = 0;

    unidade_controle_rodadas #(.N_RODADAS(N), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .jogar(jogar),
        .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
        .endereco_igual_rodada(endereco_igual_rodada), .fim_rodadas(fim_rodadas),
        .zera_e(zera_e), .conta_e(conta_e), .zera_r(zera_r), .conta_r(conta_r),
        .registra_r(registra_r), .limpa_r(limpa_r), .ganhou(ganhou),
        .perdeu(perdeu), .pronto(pronto), .db_timeout(db_timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Datapath model: address and round counters
    logic [4:0] end_cnt, rod_cnt;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            end_cnt <= '0;
            rod_cnt <= '0;
        end else begin
            if (zera_e) end_cnt <= '0; else if (conta_e) end_cnt <= end_cnt + 5'd1;
            if (zera_r) rod_cnt <= '0; else if (conta_r) rod_cnt <= rod_cnt + 5'd1;
        end
    end
    assign endereco_igual_rodada = (end_cnt == rod_cnt);
    assign fim_rodadas           = (rod_cnt == 5'(N - 1));

    // {state, zera_e, conta_e, zera_r, conta_r, registra_r, limpa_r, ganhou, perdeu, pronto, db_timeout}
    function automatic logic [13:0] expect_vec(input logic [3:0] s);
        logic [9:0] o;
        case (s)
            4'h0: o = 10'b1010000000;
            4'h1: o = 10'b1010010000;
            4'h2: o = 10'b1000000000;
            4'h4: o = 10'b0000100000;
            4'h6: o = 10'b0100000000;
            4'h7: o = 10'b0001000000;
            4'hA: o = 10'b0000001010;
            4'hE: o = 10'b0000000110;
            4'hD: o = 10'b0000000111;
            default: o = 10'b0;
        endcase
        return {s, o};
    endfunction

    logic [13:0] exp_q[$];

    task automatic push(input logic [3:0] s);
        exp_q.push_back(expect_vec(s));
    endtask

    logic [3:0]  prev_estado = 4'h0;
    logic [13:0] act_vec, exp_vec;

    always @(negedge clock) begin
        if (conta_e) n_conta_e++;
        if (conta_r) n_conta_r++;
        if (db_estado != prev_estado) begin
            prev_estado = db_estado;
            act_vec = {db_estado, zera_e, conta_e, zera_r, conta_r, registra_r,
                       limpa_r, ganhou, perdeu, pronto, db_timeout};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_transition: got %h, required no transition", act_vec);
            end else begin
                exp_vec = exp_q.pop_front();
                if (act_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL transition: got %h, required %h", act_vec, exp_vec);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (db_estado != s && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, {28'b0, db_estado}, {28'b0, s});
    endtask

    // Called at a negedge in inicial or an end state; returns at the first negedge in 0x3.
    task automatic start_game(input string name);
        push(4'h1); push(4'h2); push(4'h3);
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        wait_state(4'h3, 10, name);
    endtask

    // Called at a negedge in 0x3; plays (r, p) and waits for the resulting settle state.
    task automatic play(input bit ok, input int r, input int p);
        logic [3:0] tgt;
        push(4'h4); push(4'h5);
        if (!ok) begin
            push(4'hE); tgt = 4'hE;
        end else if (p < r) begin
            push(4'h6); push(4'h3); tgt = 4'h3;
        end else if (r < N - 1) begin
            push(4'h7); push(4'h2); push(4'h3); tgt = 4'h3;
        end else begin
            push(4'hA); tgt = 4'hA;
        end
        jogada_correta = ok;
        jogada_feita = 1'b1;
        @(negedge clock);
        jogada_feita = 1'b0;
        wait_state(tgt, 10, "play_settle");
        jogada_correta = 1'b1;
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        #2;
        check("reset_state", {28'b0, db_estado}, 32'h0);
        check("reset_outputs",
              {22'b0, zera_e, conta_e, zera_r, conta_r, registra_r, limpa_r,
               ganhou, perdeu, pronto, db_timeout}, 32'b1010000000);
        @(negedge clock);
        reset = 1'b1;

        // Start with jogar held for 5 cycles
        push(4'h1); push(4'h2); push(4'h3);
        jogar = 1'b1;
        repeat (5) @(negedge clock);
        jogar = 1'b0;
        check("start_held_state", {28'b0, db_estado}, 32'h3);
        check("start_pronto", {31'b0, pronto}, 32'h0);

        // Full winning game
        n_conta_e = 0;
        n_conta_r = 0;
        for (int r = 0; r < N; r++)
            for (int p = 0; p <= r; p++)
                play(1'b1, r, p);
        check("win_ganhou_pronto", {30'b0, ganhou, pronto}, 32'h3);
        check("win_conta_e_count", n_conta_e, 32'd120);
        check("win_conta_r_count", n_conta_r, 32'd15);

        // Loss at round 3, play 2
        start_game("restart_from_win");
        for (int r = 0; r <= 3; r++)
            for (int p = 0; p <= r; p++)
                if (r < 3 || p < 2) play(1'b1, r, p);
        play(1'b0, 3, 2);
        check("loss_flags", {29'b0, ganhou, perdeu, pronto}, 32'h3);

        // Timeout with no play
        start_game("restart_from_loss");
        push(4'hD);
        n = 0;
        while (db_estado != 4'hD && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("timeout_latency", n, TO);
        check("timeout_flag", {31'b0, db_timeout}, 32'h1);

        // Play on the same cycle the counter reaches TIMEOUT-1
        start_game("restart_from_timeout");
        push(4'h4); push(4'h5); push(4'h7); push(4'h2); push(4'h3);
        repeat (TO - 1) @(negedge clock);
        jogada_feita = 1'b1;
        @(negedge clock);
        jogada_feita = 1'b0;
        check("collision_registra", {28'b0, db_estado}, 32'h4);
        wait_state(4'h3, 10, "collision_settle");
        check("collision_no_timeout", {31'b0, db_timeout}, 32'h0);

        // Asynchronous reset mid-round
        push(4'h0);
        #1 reset = 1'b0;
        #1 check("async_reset_midround", {28'b0, db_estado}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Reset while in an end state, then restart from an end state
        start_game("restart_after_reset");
        push(4'hD);
        wait_state(4'hD, TO + 5, "timeout_again");
        push(4'h0);
        #1 reset = 1'b0;
        #1 check("async_reset_endstate",
                 {24'b0, db_estado, perdeu, pronto, db_timeout, 1'b0}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        start_game("restart_after_end_reset");
        push(4'hD);
        wait_state(4'hD, TO + 5, "timeout_third");
        start_game("restart_clears_flags");
        check("flags_clear", {29'b0, perdeu, pronto, db_timeout}, 32'h0);

        repeat (2) @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
